// File: rtl/clock_sel_pkg.sv
// Shared definitions for the clock-select handshake (requester, selector and their benches).
package clock_sel_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT_LO = 3'd1,
    RAISE   = 3'd2,
    WAIT_HI = 3'd3,
    ERR     = 3'd4
  } state_t;

  localparam logic SEL_CLK1 = 1'b0;
  localparam logic SEL_CLK2 = 1'b1;

endpackage

// File: rtl/ack_sync.sv
// Multi-flop synchronizer for an asynchronous ack returning from clock_selector.
module ack_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  always_ff @(posedge clk) begin
    if (rst) sr <= '0;
    else     sr <= {sr[STAGES-2:0], d};
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/clock_switch_requester.sv
// Initiator side of the clock_selector req/ack handshake: break-before-make switching,
// synchronized acks, per-wait timeout with a sticky error.
module clock_switch_requester
  import clock_sel_pkg::*;
#(
  parameter int   SYNC_STAGES    = 2,
  parameter int   TIMEOUT_CYCLES = 1024,
  parameter logic RESET_SEL      = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic cmd_valid,
  input  logic cmd_sel,
  output logic cmd_ready,
  input  logic ack_clk1,
  input  logic ack_clk2,
  output logic req_clk1,
  output logic req_clk2,
  output logic cur_sel,
  output logic done,
  output logic err
);

  localparam int              CW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_MAX = CW'(TIMEOUT_CYCLES);

  state_t        state, state_n;
  logic          target, target_n, cur_n;
  logic          req1_n, req2_n, done_n, err_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          ack1_s, ack2_s, ack_old, ack_tgt, timeout;

  ack_sync #(.STAGES(SYNC_STAGES)) u_sync1 (.clk(clk), .rst(rst), .d(ack_clk1), .q(ack1_s));
  ack_sync #(.STAGES(SYNC_STAGES)) u_sync2 (.clk(clk), .rst(rst), .d(ack_clk2), .q(ack2_s));

  // cur_sel still names the old source until the switch completes
  assign ack_old   = (cur_sel == SEL_CLK2) ? ack2_s : ack1_s;
  assign ack_tgt   = (target  == SEL_CLK2) ? ack2_s : ack1_s;
  assign timeout   = (cnt == CNT_MAX);
  assign cmd_ready = (state == IDLE);

  always_comb begin
    state_n  = state;
    target_n = target;
    cur_n    = cur_sel;
    req1_n   = req_clk1;
    req2_n   = req_clk2;
    done_n   = 1'b0;
    err_n    = err;
    cnt_n    = cnt;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_sel == cur_sel) begin
            done_n = 1'b1;
          end else begin
            target_n = cmd_sel;
            if (cur_sel == SEL_CLK1) req1_n = 1'b0;
            else                     req2_n = 1'b0;
            cnt_n   = '0;
            state_n = WAIT_LO;
          end
        end
      end
      WAIT_LO: begin
        if (!ack_old)     state_n = RAISE;
        else if (timeout) state_n = ERR;
        else              cnt_n   = cnt + CW'(1);
      end
      RAISE: begin
        if (target == SEL_CLK1) req1_n = 1'b1;
        else                    req2_n = 1'b1;
        cnt_n   = '0;
        state_n = WAIT_HI;
      end
      WAIT_HI: begin
        if (ack_tgt) begin
          cur_n   = target;
          done_n  = 1'b1;
          state_n = IDLE;
        end else if (timeout) begin
          state_n = ERR;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      ERR:     state_n = ERR;
      default: state_n = ERR;
    endcase
    // Outputs are registered, so ERR's values are loaded on the edge that enters it
    if (state_n == ERR) begin
      req1_n = 1'b0;
      req2_n = 1'b0;
      err_n  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RAISE;
      target   <= RESET_SEL;
      cur_sel  <= RESET_SEL;
      req_clk1 <= 1'b0;
      req_clk2 <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      cnt      <= '0;
    end else begin
      state    <= state_n;
      target   <= target_n;
      cur_sel  <= cur_n;
      req_clk1 <= req1_n;
      req_clk2 <= req2_n;
      done     <= done_n;
      err      <= err_n;
      cnt      <= cnt_n;
    end
  end

endmodule

// File: tb/tb_clock_switch_requester.sv
// Randomized scoreboard bench: behavioural clock_selector with programmable ack delays.
module tb_clock_switch_requester;

  localparam int   SYNC    = 2;
  localparam int   TMO     = 16;
  localparam logic RST_SEL = 1'b0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmd_valid = 1'b0, cmd_sel = 1'b0;
  logic cmd_ready, ack_clk1, ack_clk2, req_clk1, req_clk2, cur_sel, done, err;

  clock_switch_requester #(.SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TMO), .RESET_SEL(RST_SEL)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_sel(cmd_sel), .cmd_ready(cmd_ready),
    .ack_clk1(ack_clk1), .ack_clk2(ack_clk2), .req_clk1(req_clk1), .req_clk2(req_clk2),
    .cur_sel(cur_sel), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Selector model: each ack follows its req d cycles later; hold2 pins ack_clk2 low
  logic [15:0] h1 = '0, h2 = '0;
  int d1 = 3, d2 = 3;
  bit hold2 = 1'b0;
  always @(posedge clk) begin
    h1 <= {h1[14:0], req_clk1};
    h2 <= {h2[14:0], req_clk2};
  end
  assign ack_clk1 = h1[d1-1];
  assign ack_clk2 = hold2 ? 1'b0 : h2[d2-1];

  int   checks = 0, fails = 0, done_seen = 0;
  logic sb[$];
  logic model_cur = RST_SEL;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Monitor: every done must match the oldest outstanding expected completion
  always @(negedge clk) begin
    if (!rst) begin
      chk("break_before_make", {31'd0, req_clk1 & req_clk2}, 0);
      if (done === 1'b1) begin
        done_seen++;
        if (sb.size() == 0) begin
          checks++; fails++;
          $display("FAIL unexpected_done: got done=1 expected no completion pending");
        end else begin
          logic e;
          e = sb.pop_front();
          chk("done_cur_sel", cur_sel, e);
          chk("done_req_active", e ? req_clk2 : req_clk1, 1);
          chk("done_req_other", e ? req_clk1 : req_clk2, 0);
        end
      end
    end
  end

  task automatic wait_done(input int tgt);
    int n = 0;
    while (done_seen < tgt && n < 80) begin @(posedge clk); #1; n++; end
    chk("done_arrived", done_seen >= tgt, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; cmd_valid = 1'b0; sb.delete();
    @(posedge clk); #1;
    chk("rst_req1", req_clk1, 0);
    chk("rst_req2", req_clk2, 0);
    chk("rst_ready", cmd_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_cur_sel", cur_sel, RST_SEL);
    @(negedge clk);
    rst = 1'b0; model_cur = RST_SEL; sb.push_back(RST_SEL);
  endtask

  task automatic check_idle(input logic sel);
    chk("idle_cur_sel", cur_sel, sel);
    chk("idle_req_sel", sel ? req_clk2 : req_clk1, 1);
    chk("idle_req_other", sel ? req_clk1 : req_clk2, 0);
    chk("idle_ready", cmd_ready, 1);
    chk("idle_err", err, 0);
  endtask

  task automatic send(input logic sel, input bit expect_done);
    int n, rise_n, tgt;
    bit sw;
    logic old;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
    chk("ready_before_cmd", cmd_ready, 1);
    sw = (sel != model_cur); old = model_cur; tgt = done_seen + 1;
    cmd_sel = sel; cmd_valid = 1'b1;
    if (expect_done) sb.push_back(sel);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    if (expect_done) model_cur = sel;
    if (!sw) begin
      chk("noop_ready", cmd_ready, 1);
      chk("noop_req", sel ? req_clk2 : req_clk1, 1);
    end else begin
      chk("old_req_fall", old ? req_clk2 : req_clk1, 0);
      n = 0; rise_n = -1;
      while (n < 60 && ((expect_done && done_seen < tgt) || (!expect_done && rise_n < 0))) begin
        @(posedge clk); #1; n++;
        // stray commands while busy must be dropped
        if (n <= 2) begin cmd_valid = 1'($urandom_range(0, 1)); cmd_sel = 1'($urandom_range(0, 1)); end
        else cmd_valid = 1'b0;
        if (rise_n < 0 && (sel ? req_clk2 : req_clk1) === 1'b1) rise_n = n;
      end
      cmd_valid = 1'b0;
      chk_range("req_rise_latency", rise_n, SYNC + 2, 60);
    end
    if (expect_done) wait_done(tgt);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // bring-up after reset
    do_reset();
    wait_done(done_seen + 1);
    check_idle(1'b0);

    // directed switch 0->1 with distinct ack delays
    d1 = 4; d2 = 5;
    send(1'b1, 1'b1);
    check_idle(1'b1);

    // no-op command
    send(1'b1, 1'b1);
    check_idle(1'b1);

    // ack glitch on current source while idle
    hold2 = 1'b1;
    repeat (3) @(posedge clk);
    #1 hold2 = 1'b0;
    repeat (8) @(posedge clk);
    #1 check_idle(1'b1);

    // switch back with busy pulses, then random traffic
    send(1'b0, 1'b1);
    check_idle(1'b0);
    for (int i = 0; i < 20; i++) begin
      d1 = $urandom_range(1, 6); d2 = $urandom_range(1, 6);
      repeat (8) @(posedge clk);
      #1 send(1'($urandom_range(0, 1)), 1'b1);
      check_idle(model_cur);
    end

    // reset while waiting for the old ack to drop
    if (model_cur != 1'b1) send(1'b1, 1'b1);
    d2 = 6;
    repeat (8) @(posedge clk);
    #1 cmd_sel = 1'b0; cmd_valid = 1'b1;
    @(posedge clk); #1 cmd_valid = 1'b0;
    chk("wait_lo_req2_low", req_clk2, 0);
    @(posedge clk); #1;
    do_reset();
    wait_done(done_seen + 1);
    check_idle(1'b0);

    // timeout in WAIT_HI with ack_clk2 stuck low
    d1 = 3; d2 = 3;
    hold2 = 1'b1;
    send(1'b1, 1'b0);
    n = 0;
    while (err !== 1'b1 && n < 60) begin @(posedge clk); #1; n++; end
    chk_range("timeout_cycles", n, TMO, TMO + 2);
    chk("err_set", err, 1);
    chk("err_req1", req_clk1, 0);
    chk("err_req2", req_clk2, 0);
    chk("err_ready", cmd_ready, 0);
    cmd_sel = 1'b0; cmd_valid = 1'b1;
    repeat (4) @(posedge clk);
    #1 cmd_valid = 1'b0;
    chk("err_sticky", err, 1);
    chk("err_ready_held", cmd_ready, 0);
    hold2 = 1'b0;
    do_reset();
    wait_done(done_seen + 1);
    check_idle(1'b0);
    send(1'b1, 1'b1);
    check_idle(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
